// File: rtl/life_engine_if.sv
`timescale 1ns/1ps
// Control, cell-edit and renderer read signals of the Game-of-Life engine.
// The master side drives controls and the read address; the slave side is the engine.
interface life_engine_if #(
    parameter int AW = 6
);
    logic          frame_tick;
    logic          run;
    logic          step;
    logic          load;
    logic          wrap_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          busy;
    logic [15:0]   gen_count;

    modport master (
        output frame_tick, run, step, load, wrap_en, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, gen_count
    );

    modport slave (
        input  frame_tick, run, step, load, wrap_en, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, gen_count
    );
endinterface

// File: rtl/life_engine.sv
`timescale 1ns/1ps
// Game-of-Life engine: one cell per clock into a shadow board, whole-board commit.
// Latency SIZE+2 cycles from trigger to visible generation; read port is combinational.
// No backpressure: step/edit requests while busy are dropped, load aborts any compute.
module life_engine #(
    parameter int BIT_WIDTH      = 3,
    parameter int BIT_HEIGHT     = 3,
    parameter int FRAMES_PER_GEN = 60,
    parameter logic [(2**BIT_WIDTH)*(2**BIT_HEIGHT)-1:0] SEED = '0
) (
    input  logic          clk,
    input  logic          reset,
    life_engine_if.slave  bus
);
    localparam int SIZE = (2**BIT_WIDTH) * (2**BIT_HEIGHT);
    localparam int AW   = BIT_WIDTH + BIT_HEIGHT;
    localparam int FC_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   cur, nxt;
    logic [AW-1:0]     idx;
    logic [FC_W-1:0]   frame_cnt;
    logic [15:0]       gen_count;

    logic [BIT_WIDTH-1:0]  x, nx;
    logic [BIT_HEIGHT-1:0] y, ny;
    logic                  x_off, y_off;
    logic [3:0]            ncount;
    logic                  next_cell;
    logic                  frame_hit;
    logic                  start;

    assign x = idx[BIT_WIDTH-1:0];
    assign y = idx[AW-1:BIT_WIDTH];

    // Power-of-two board: plain truncating adds give the toroidal wrap for free,
    // so only the non-wrapping case needs explicit edge detection.
    always_comb begin
        ncount = '0;
        nx     = '0;
        ny     = '0;
        x_off  = 1'b0;
        y_off  = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    nx    = x + dx[BIT_WIDTH-1:0];
                    ny    = y + dy[BIT_HEIGHT-1:0];
                    x_off = (dx == -1 && x == '0) || (dx == 1 && x == '1);
                    y_off = (dy == -1 && y == '0) || (dy == 1 && y == '1);
                    if (bus.wrap_en || !(x_off || y_off))
                        ncount = ncount + 4'(cur[{ny, nx}]);
                end
            end
        end
    end

    assign next_cell = (ncount == 4'd3) || (cur[idx] && ncount == 4'd2);
    assign frame_hit = bus.frame_tick && bus.run && (frame_cnt == FC_W'(FRAMES_PER_GEN - 1));
    assign start     = (state_q == IDLE) && !bus.load && !bus.wr_en && (bus.step || frame_hit);

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = COMPUTE;
                COMPUTE: if (idx == AW'(SIZE - 1)) state_d = COMMIT;
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur       <= SEED;
            nxt       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            gen_count <= '0;
        end else begin
            state_q <= state_d;
            // The frame divider free-runs with run, so a terminal count hit while busy is lost.
            if (bus.frame_tick && bus.run)
                frame_cnt <= frame_hit ? '0 : frame_cnt + 1'b1;
            if (bus.load) begin
                cur <= SEED;
                idx <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.wr_en)
                            cur[bus.wr_addr] <= bus.wr_data;
                        else if (start)
                            idx <= '0;
                    end
                    COMPUTE: begin
                        nxt[idx] <= next_cell;
                        idx      <= idx + 1'b1;
                    end
                    COMMIT: begin
                        cur       <= nxt;
                        gen_count <= gen_count + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_data   = cur[bus.rd_addr];
    assign bus.busy      = (state_q != IDLE);
    assign bus.gen_count = gen_count;
endmodule

// File: tb/tb_life_engine.sv
`timescale 1ns/1ps
// Bench for life_engine: 8x8 board seeded with a glider, two frames per generation.
module tb_life_engine;
    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
    localparam int SIZE = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    life_engine_if #(.AW(6)) bus ();

    life_engine #(
        .BIT_WIDTH(3), .BIT_HEIGHT(3), .FRAMES_PER_GEN(2), .SEED(GLIDER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: next generation straight from the rules, coordinates by integer arithmetic.
    function automatic logic [63:0] life(input logic [63:0] b, input logic w);
        logic [63:0] r;
        int n, xx, yy;
        r = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        xx = x + dx;
                        yy = y + dy;
                        if (w) begin
                            xx = (xx + 8) % 8;
                            yy = (yy + 8) % 8;
                        end else if (xx < 0 || xx > 7 || yy < 0 || yy > 7) begin
                            continue;
                        end
                        n += int'(b[yy*8+xx]);
                    end
                end
                r[y*8+x] = (n == 3) || (b[y*8+x] && n == 2);
            end
        end
        return r;
    endfunction

    // Model: board, generation count, cycles left until the pending generation lands.
    logic [63:0] m_board;
    int          m_gen = 0;
    int          m_rem = 0;
    int          m_fc  = 0;
    bit          m_valid = 0;
    bit          fire;

    always @(posedge clk) begin
        if (reset) begin
            m_board = GLIDER;
            m_gen   = 0;
            m_rem   = 0;
            m_fc    = 0;
            m_valid = 1;
        end else begin
            fire = 0;
            if (bus.frame_tick && bus.run) begin
                if (m_fc == 1) begin fire = 1; m_fc = 0; end
                else m_fc++;
            end
            if (bus.load) begin
                m_board = GLIDER;
                m_rem   = 0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_board = life(m_board, bus.wrap_en);
                    m_gen   = (m_gen + 1) % 65536;
                end
            end else if (bus.wr_en) begin
                m_board[bus.wr_addr] = bus.wr_data;
            end else if (bus.step || fire) begin
                m_rem = SIZE + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("cyc_busy", {63'b0, bus.busy}, {63'b0, m_rem > 0});
            chk("cyc_gen_count", {48'b0, bus.gen_count}, 64'(m_gen));
            chk("cyc_rd_data", {63'b0, bus.rd_data}, {63'b0, m_board[bus.rd_addr]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk); bus.step = 1'b1;
        @(negedge clk); bus.step = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); bus.frame_tick = 1'b1;
        @(negedge clk); bus.frame_tick = 1'b0;
    endtask

    task automatic scan(input string tag, input logic [63:0] mask);
        chk({"model_", tag}, m_board, mask);
        for (int a = 0; a < SIZE; a++) begin
            @(negedge clk);
            bus.rd_addr = 6'(a);
            #1;
            chk($sformatf("%s_cell%0d", tag, a), {63'b0, bus.rd_data}, {63'b0, mask[a]});
        end
    endtask

    // Step at cycle T, return at the negedge inside T+SIZE+2.
    task automatic gen_step();
        pulse_step();
        cyc(SIZE + 1);
    endtask

    localparam logic [63:0] VERT_BLINK  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] HORIZ_BLINK = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] WRAP_VERT   = 64'h0000_0001_0101_0000;
    localparam logic [63:0] SPAN_ROW3   = 64'h0000_0000_8300_0000;
    localparam int          AUTO_GEN[6] = '{4, 5, 5, 6, 6, 7};

    initial begin
        bus.frame_tick = 0; bus.run = 0; bus.step = 0; bus.load = 0;
        bus.wrap_en = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = 0; bus.rd_addr = '0;
        cyc(2);
        reset = 1'b0;
        chk("reset_busy", {63'b0, bus.busy}, 64'd0);
        chk("reset_gen", {48'b0, bus.gen_count}, 64'd0);
        scan("reset_board", GLIDER);

        // Blinker, no wrap
        wr(1, 0); wr(10, 0); wr(16, 0); wr(17, 0); wr(18, 0);
        wr(19, 1); wr(27, 1); wr(35, 1);
        gen_step();
        chk("blink1_gen", {48'b0, bus.gen_count}, 64'd1);
        scan("blink1", HORIZ_BLINK);
        gen_step();
        chk("blink2_gen", {48'b0, bus.gen_count}, 64'd2);
        scan("blink2", VERT_BLINK);

        // Row-3 blinker straddling the left/right edge
        wr(19, 0); wr(27, 0); wr(35, 0);
        bus.wrap_en = 1'b1;
        wr(31, 1); wr(24, 1); wr(25, 1);
        scan("span_start", SPAN_ROW3);
        gen_step();
        scan("wrap_on", WRAP_VERT);
        wr(16, 0); wr(24, 0); wr(32, 0);
        bus.wrap_en = 1'b0;
        wr(31, 1); wr(24, 1); wr(25, 1);
        gen_step();
        chk("wrap_off_gen", {48'b0, bus.gen_count}, 64'd4);
        scan("wrap_off", 64'd0);

        // Automatic generations every second frame
        wr(19, 1); wr(27, 1); wr(35, 1);
        bus.run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            cyc(70);
            chk($sformatf("auto_tick%0d_gen", i + 1), {48'b0, bus.gen_count}, 64'(AUTO_GEN[i]));
        end
        scan("auto_board", HORIZ_BLINK);
        bus.run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cyc(70);
        end
        chk("norun_gen", {48'b0, bus.gen_count}, 64'd7);

        // step and write while busy are ignored
        pulse_step();
        cyc(4);
        @(negedge clk);
        bus.step = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 6'd0; bus.wr_data = 1'b1;
        @(negedge clk);
        bus.step = 1'b0; bus.wr_en = 1'b0;
        cyc(58);
        chk("busy_at_65", {63'b0, bus.busy}, 64'd1);
        cyc(1);
        chk("busy_at_66", {63'b0, bus.busy}, 64'd0);
        chk("busy_rej_gen", {48'b0, bus.gen_count}, 64'd8);
        scan("busy_rej", VERT_BLINK);
        cyc(70);
        chk("busy_rej_gen_late", {48'b0, bus.gen_count}, 64'd8);

        // load aborts compute
        pulse_step();
        cyc(8);
        @(negedge clk); bus.load = 1'b1;
        @(negedge clk); bus.load = 1'b0;
        chk("load_busy", {63'b0, bus.busy}, 64'd0);
        chk("load_gen", {48'b0, bus.gen_count}, 64'd8);
        scan("load_board", GLIDER);
        cyc(70);
        chk("load_gen_late", {48'b0, bus.gen_count}, 64'd8);

        // reset mid-compute
        pulse_step();
        cyc(20);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_busy", {63'b0, bus.busy}, 64'd0);
        chk("rst_gen", {48'b0, bus.gen_count}, 64'd0);
        scan("rst_board", GLIDER);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
